// File: rtl/lsu_mem_access.sv
//==========================================================================
// lsu_mem_access : LSU memory-access stage (IDLE/REQ/RESP handshake to data memory)
// Optional trap on misaligned access: define LSU_MISALIGN_TRAP_EN.  Rev 1.0
//==========================================================================
`default_nettype none

module lsu_mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        is_nop,
  input  logic        is_load,
  input  logic [4:0]  rd,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        valid_out,
  output logic        is_nop_out,
  output logic        is_load_out,
  output logic [4:0]  rd_out,
  output logic [1:0]  size_out,
  output logic        zero_ext_out,
  output logic [31:0] data_out,
  output logic        misalign_err,
  output logic        illegal_err,
  output logic        timeout_err
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] to_cnt;
  logic [1:0]  addr_lo;
  logic        is_load_q;
  logic        accept, illegal_now, misalign_now, no_access, to_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt, rdata_aligned;

  assign accept      = (state == ST_IDLE) && valid_in;
  assign illegal_now = !is_nop && (size == 2'b11);
  assign to_hit      = (to_cnt == TO_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_now = !is_nop && (((size == 2'b01) && addr[0]) ||
                                    ((size == 2'b10) && (addr[1:0] != 2'b00)));
`else
  assign misalign_now = 1'b0;
`endif

  assign no_access = is_nop || illegal_now || misalign_now;

  // Combinational outputs decode straight from state so reset drops mem_req at once.
  assign ready_out   = (state == ST_IDLE);
  assign mem_req     = (state == ST_REQ);
  assign valid_out   = (state == ST_RESP);
  assign is_load_out = is_load_q && !(illegal_err || misalign_err || timeout_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (valid_in) state_nxt = no_access ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_ack || to_hit) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = store_data;
    case (size)
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_aligned = mem_rdata;
    case (size_out)
      2'b00:   rdata_aligned = mem_rdata >> {addr_lo, 3'b000};
      2'b01:   rdata_aligned = mem_rdata >> {addr_lo[1], 4'b0000};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt       <= '0;
      addr_lo      <= '0;
      is_load_q    <= 1'b0;
      is_nop_out   <= 1'b0;
      rd_out       <= '0;
      size_out     <= '0;
      zero_ext_out <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      data_out     <= '0;
      misalign_err <= 1'b0;
      illegal_err  <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (accept) begin
      to_cnt       <= '0;
      addr_lo      <= addr[1:0];
      is_load_q    <= is_load && !is_nop;
      is_nop_out   <= is_nop;
      rd_out       <= rd;
      size_out     <= size;
      zero_ext_out <= zero_ext;
      mem_we       <= !is_nop && !is_load && !no_access;
      mem_addr     <= {addr[31:2], 2'b00};
      mem_be       <= be_nxt;
      mem_wdata    <= wdata_nxt;
      data_out     <= '0;
      misalign_err <= misalign_now;
      illegal_err  <= illegal_now;
      timeout_err  <= 1'b0;
    end else if (state == ST_REQ) begin
      // An ack in the final timeout cycle takes priority over the abort.
      if (mem_ack) begin
        data_out <= rdata_aligned;
        mem_we   <= 1'b0;
      end else if (to_hit) begin
        timeout_err <= 1'b1;
        mem_we      <= 1'b0;
      end else begin
        to_cnt <= to_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire
